branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with saturating-counter direction prediction for the pipelined MIPS core. It sits in IF beside the PC adder. Each cycle it offers a predicted next PC for the fetch address. It is trained from ID, where branches and jumps resolve, so that taken branches stop costing an IF_ID flush. After reset or `clear_i`, a sequential init walk invalidates the table one entry per cycle.

## Interface
- `ADDR_W`, default 32: PC width.
- `ENTRIES`, default 16: table depth; must be a power of 2, minimum 2.
- `CNT_W`, default 2: counter width, minimum 1.
- `MISS_W`, default 16: mispredict counter width.
- Derived: `IDX_W` = log2(`ENTRIES`); `TAG_W` = `ADDR_W`-2-`IDX_W`. Index = pc[`IDX_W`+1:2]; tag = pc[`ADDR_W`-1:`IDX_W`+2].

Ports:
- `clk_i`  in  1  clock. One clock domain; reset is synchronous and active-high.
- `rst_i`  in  1  synchronous active-high reset.
- `clear_i`  in  1  restart the invalidation walk.
- `pc_i`  in  `ADDR_W`  fetch PC for lookup.
- `hit_o`  out  1  valid tag match for `pc_i`.
- `pred_taken_o`  out  1  `hit_o` & counter MSB.
- `next_pc_o`  out  `ADDR_W`  stored target if `pred_taken_o`, else `pc_i`+4.
- `upd_valid_i`  in  1  update strobe from ID.
- `upd_pc_i`  in  `ADDR_W`  PC of the resolved branch.
- `upd_taken_i`  in  1  resolved direction.
- `upd_target_i`  in  `ADDR_W`  resolved target.
- `upd_mispredict_i`  in  1  ID detected a wrong prediction.
- `busy_o`  out  1  high during reset and the init walk.
- `miss_cnt_o`  out  `MISS_W`  saturating mispredict count.

## Operation
Per entry, the table holds `valid` (1), `tag` (`TAG_W`), `target` (`ADDR_W`) and `cnt` (`CNT_W`).

State machine INIT / READY:
- `rst_i` high at an edge: state goes to INIT, walk index goes to 0, `miss_cnt_o` goes to 0.
- INIT, each edge: clear `valid` of entry [idx] and increment idx. The edge that clears entry `ENTRIES`-1 moves the state to READY.
- READY with `clear_i` high: state goes to INIT, idx goes to 0. `clear_i` in INIT restarts the walk at idx 0.
- `clear_i` does not clear `miss_cnt_o`.

Lookup is combinational from registered table state:
- INIT: `hit_o` = 0, `pred_taken_o` = 0, `next_pc_o` = `pc_i`+4.
- READY: `hit_o` = valid[idx] & (tag == pc tag).
- `pc_i`+4 wraps modulo 2^`ADDR_W`.

Update, at an edge in READY with `upd_valid_i` high and `clear_i` low:
- Hit on `upd_pc_i`:
  - Taken: `cnt` increments, saturating at 2^`CNT_W`-1, and `target` is overwritten with `upd_target_i`.
  - Not taken: `cnt` decrements, saturating at 0.
- Miss and taken: allocate the entry. Set valid=1, tag, target, and `cnt` = 2^(`CNT_W`-1) (weakly taken). This overwrites whatever occupied the index.
- Miss and not taken: no table change.
- `upd_mispredict_i` high: `miss_cnt_o` increments, saturating at all-ones.

Ignored inputs:
- Updates in INIT or during `rst_i` are dropped, including the miss count.
- `clear_i` together with `upd_valid_i` in READY: clear wins and the update is dropped.

## Timing
- Reset values: state INIT, `busy_o` = 1, `hit_o` = 0, `pred_taken_o` = 0, `miss_cnt_o` = 0.
- `busy_o` = (state == INIT).
- Init length: `busy_o` falls exactly `ENTRIES` edges after the first edge with `rst_i` low. For example, with `ENTRIES`=16, reset is released before edge 0 and READY holds from edge 15 onward.
- Lookup latency: 0 cycles, combinational from `pc_i`.
- Update latency: 1 cycle. The table changes at the sampling edge, and a lookup in the same cycle sees the old contents (read-before-write).
- `rst_i` mid-walk or mid-update: reset wins and the walk restarts at idx 0.
- Lookup and update to the same index in one cycle: lookup returns the pre-update entry.

## Test plan
- Reset (`ENTRIES`=16): hold `rst_i` for 2 cycles, then release. Required: `busy_o`=1 for exactly 16 cycles, `hit_o`=0 throughout, and `next_pc_o`=0x00400004 for `pc_i`=0x00400000.
- Allocate: update pc=0x00400010, taken, target 0x00400100. Next cycle, `pc_i`=0x00400010 must give `hit_o`=1, `pred_taken_o`=1 (cnt=2), `next_pc_o`=0x00400100.
- Saturate: starting from cnt=2, apply 3 taken updates (cnt=3), then 2 not-taken updates. Required: cnt=1 and `pred_taken_o`=0 with `hit_o`=1. A 3rd not-taken update leaves cnt=0, and a 4th keeps cnt=0.
- Alias: update pc=0x00400050 taken (same index 4, different tag). Required: pc=0x00400010 misses (`next_pc_o`=0x00400014) and pc=0x00400050 hits. A not-taken miss at 0x00400090 must change nothing.
- Clear/collision: assert `clear_i` together with `upd_valid_i` + `upd_mispredict_i`. Required: `busy_o`=1 for 16 cycles, all entries miss afterwards, `miss_cnt_o` unchanged, and updates during INIT are dropped.
- Miss counter (`MISS_W`=4): apply 17 mispredict updates. Required: `miss_cnt_o`=0xF. `rst_i` returns it to 0.

Source files
------------

// File: rtl/branch_predictor.sv
// Branch target buffer with per-entry saturating direction counters for the IF stage.
// Trained from ID; an init walk invalidates one entry per cycle after reset or clear.
module branch_predictor #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned ENTRIES = 16,
    parameter int unsigned CNT_W   = 2,
    parameter int unsigned MISS_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic              hit_o,
    output logic              pred_taken_o,
    output logic [ADDR_W-1:0] next_pc_o,
    input  logic              upd_valid_i,
    input  logic [ADDR_W-1:0] upd_pc_i,
    input  logic              upd_taken_i,
    input  logic [ADDR_W-1:0] upd_target_i,
    input  logic              upd_mispredict_i,
    output logic              busy_o,
    output logic [MISS_W-1:0] miss_cnt_o
);

    localparam int unsigned IDX_W = $clog2(ENTRIES);
    localparam int unsigned TAG_W = ADDR_W - 2 - IDX_W;
    localparam logic [CNT_W-1:0] CntMax  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntWeak = CNT_W'(1 << (CNT_W - 1));

    typedef enum logic [0:0] {StInit, StReady} state_e;

    state_e             state;
    logic [IDX_W-1:0]   walk_idx;
    logic [MISS_W-1:0]  miss_cnt;

    logic               valid  [ENTRIES];
    logic [TAG_W-1:0]   tag    [ENTRIES];
    logic [ADDR_W-1:0]  target [ENTRIES];
    logic [CNT_W-1:0]   cnt    [ENTRIES];

    logic [IDX_W-1:0]   lk_idx;
    logic [TAG_W-1:0]   lk_tag;
    logic [IDX_W-1:0]   up_idx;
    logic [TAG_W-1:0]   up_tag;
    logic               up_hit;
    logic               unused_pc_bits;

    assign lk_idx = pc_i[IDX_W+1:2];
    assign lk_tag = pc_i[ADDR_W-1:IDX_W+2];
    assign up_idx = upd_pc_i[IDX_W+1:2];
    assign up_tag = upd_pc_i[ADDR_W-1:IDX_W+2];
    assign unused_pc_bits = ^{pc_i[1:0], upd_pc_i[1:0]};

    assign up_hit = valid[up_idx] && (tag[up_idx] == up_tag);

    // Lookup reads registered state only, so a same-cycle update is seen next cycle.
    assign hit_o        = (state == StReady) && valid[lk_idx] && (tag[lk_idx] == lk_tag);
    assign pred_taken_o = hit_o && cnt[lk_idx][CNT_W-1];
    assign next_pc_o    = pred_taken_o ? target[lk_idx] : pc_i + ADDR_W'(4);
    assign busy_o       = (state == StInit);
    assign miss_cnt_o   = miss_cnt;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state    <= StInit;
            walk_idx <= '0;
            miss_cnt <= '0;
        end else begin
            unique case (state)
                StInit: begin
                    if (clear_i) begin
                        walk_idx <= '0;
                    end else begin
                        valid[walk_idx] <= 1'b0;
                        walk_idx        <= walk_idx + 1'b1;
                        if (walk_idx == IDX_W'(ENTRIES - 1)) begin
                            state <= StReady;
                        end
                    end
                end
                StReady: begin
                    if (clear_i) begin
                        state    <= StInit;
                        walk_idx <= '0;
                    end else if (upd_valid_i) begin
                        if (up_hit) begin
                            if (upd_taken_i) begin
                                if (cnt[up_idx] != CntMax) begin
                                    cnt[up_idx] <= cnt[up_idx] + 1'b1;
                                end
                                target[up_idx] <= upd_target_i;
                            end else if (cnt[up_idx] != '0) begin
                                cnt[up_idx] <= cnt[up_idx] - 1'b1;
                            end
                        end else if (upd_taken_i) begin
                            // Allocation evicts whatever aliases to this index.
                            valid[up_idx]  <= 1'b1;
                            tag[up_idx]    <= up_tag;
                            target[up_idx] <= upd_target_i;
                            cnt[up_idx]    <= CntWeak;
                        end
                        if (upd_mispredict_i && (miss_cnt != {MISS_W{1'b1}})) begin
                            miss_cnt <= miss_cnt + 1'b1;
                        end
                    end
                end
                default: state <= StInit;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor: init walk, allocation, counter saturation,
// aliasing, clear/update collision and the saturating mispredict counter.
module tb_branch_predictor;

    logic        clk = 1'b0;
    logic        rst_i = 1'b1;
    logic        clear_i = 1'b0;
    logic [31:0] pc_i = 32'h0040_0000;
    logic        hit_o;
    logic        pred_taken_o;
    logic [31:0] next_pc_o;
    logic        upd_valid_i = 1'b0;
    logic [31:0] upd_pc_i = '0;
    logic        upd_taken_i = 1'b0;
    logic [31:0] upd_target_i = '0;
    logic        upd_mispredict_i = 1'b0;
    logic        busy_o;
    logic [3:0]  miss_cnt_o;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    branch_predictor #(
        .ADDR_W (32),
        .ENTRIES(16),
        .CNT_W  (2),
        .MISS_W (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst_i),
        .clear_i         (clear_i),
        .pc_i            (pc_i),
        .hit_o           (hit_o),
        .pred_taken_o    (pred_taken_o),
        .next_pc_o       (next_pc_o),
        .upd_valid_i     (upd_valid_i),
        .upd_pc_i        (upd_pc_i),
        .upd_taken_i     (upd_taken_i),
        .upd_target_i    (upd_target_i),
        .upd_mispredict_i(upd_mispredict_i),
        .busy_o          (busy_o),
        .miss_cnt_o      (miss_cnt_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One update strobe, applied across a single edge.
    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic mis);
        upd_valid_i      = 1'b1;
        upd_pc_i         = pc;
        upd_taken_i      = taken;
        upd_target_i     = tgt;
        upd_mispredict_i = mis;
        step();
        upd_valid_i      = 1'b0;
        upd_mispredict_i = 1'b0;
    endtask

    task automatic look(input string tag, input logic [31:0] pc, input logic hit,
                        input logic pred, input logic [31:0] npc);
        pc_i = pc;
        #1;
        check({tag, "_hit"}, 64'(hit_o), 64'(hit));
        check({tag, "_pred"}, 64'(pred_taken_o), 64'(pred));
        check({tag, "_npc"}, 64'(next_pc_o), 64'(npc));
    endtask

    task automatic count_busy(input string tag, input int exp);
        int n = 0;
        while (busy_o && n < 100) begin
            if (hit_o) begin
                check({tag, "_hit_in_init"}, 64'(hit_o), 64'd0);
            end
            n++;
            step();
        end
        check({tag, "_busy_len"}, 64'(n), 64'(exp));
    endtask

    initial begin
        // Reset held for two edges.
        step();
        check("rst_busy", 64'(busy_o), 64'd1);
        check("rst_hit", 64'(hit_o), 64'd0);
        check("rst_pred", 64'(pred_taken_o), 64'd0);
        check("rst_miss", 64'(miss_cnt_o), 64'd0);
        step();
        rst_i = 1'b0;
        check("init_npc", 64'(next_pc_o), 64'h0040_0004);
        count_busy("init", 16);
        look("ready_empty", 32'h0040_0000, 1'b0, 1'b0, 32'h0040_0004);

        // Allocate weakly taken.
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        look("alloc", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0100);

        // Saturate up (last update retargets), then down.
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0100, 1'b0);
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        look("sat_hi", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        look("cnt1", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        upd(32'h0040_0010, 1'b0, 32'h0, 1'b0);
        // From a floor of 0, one taken must still predict not-taken, a second flips it.
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        look("sat_lo", 32'h0040_0010, 1'b1, 1'b0, 32'h0040_0014);
        upd(32'h0040_0010, 1'b1, 32'h0040_0200, 1'b0);
        look("cnt2", 32'h0040_0010, 1'b1, 1'b1, 32'h0040_0200);

        // Alias at index 4; same-cycle lookup must see the old entry.
        pc_i = 32'h0040_0050;
        upd_valid_i = 1'b1; upd_pc_i = 32'h0040_0050; upd_taken_i = 1'b1;
        upd_target_i = 32'h0040_0300;
        #1;
        check("rbw_hit", 64'(hit_o), 64'd0);
        step();
        upd_valid_i = 1'b0;
        look("alias_old", 32'h0040_0010, 1'b0, 1'b0, 32'h0040_0014);
        look("alias_new", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
        upd(32'h0040_0090, 1'b0, 32'h0040_0400, 1'b0);
        look("nt_miss_keep", 32'h0040_0050, 1'b1, 1'b1, 32'h0040_0300);
        look("nt_miss_noalloc", 32'h0040_0090, 1'b0, 1'b0, 32'h0040_0094);
        upd(32'h0040_0020, 1'b1, 32'h0040_0500, 1'b0);
        look("alloc8", 32'h0040_0020, 1'b1, 1'b1, 32'h0040_0500);

        // Clear collides with an update; updates stay asserted through the walk.
        clear_i = 1'b1;
        upd_valid_i = 1'b1; upd_pc_i = 32'h0040_0060; upd_taken_i = 1'b1;
        upd_target_i = 32'h0040_0600; upd_mispredict_i = 1'b1;
        step();
        clear_i = 1'b0;
        upd_pc_i = 32'h0040_0070;
        count_busy("clear", 16);
        upd_valid_i = 1'b0;
        upd_mispredict_i = 1'b0;
        check("clear_miss", 64'(miss_cnt_o), 64'd0);
        look("clr_a", 32'h0040_0050, 1'b0, 1'b0, 32'h0040_0054);
        look("clr_b", 32'h0040_0020, 1'b0, 1'b0, 32'h0040_0024);
        look("clr_c", 32'h0040_0060, 1'b0, 1'b0, 32'h0040_0064);
        look("clr_d", 32'h0040_0070, 1'b0, 1'b0, 32'h0040_0074);

        // Mispredict counter saturates at 0xF.
        for (int i = 0; i < 17; i++) begin
            upd(32'h0040_0100, 1'b0, 32'h0, 1'b1);
            if (i == 2) begin
                check("miss_3", 64'(miss_cnt_o), 64'd3);
            end
        end
        check("miss_sat", 64'(miss_cnt_o), 64'hF);
        look("wrap_npc", 32'hFFFF_FFFC, 1'b0, 1'b0, 32'h0000_0000);

        rst_i = 1'b1;
        step();
        rst_i = 1'b0;
        check("rst2_miss", 64'(miss_cnt_o), 64'd0);
        check("rst2_busy", 64'(busy_o), 64'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
